// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared definitions for the SPI mode-0 response slave.
//   state_t        - frame FSM states
//   DATA_W_DEF     - default frame width
//   IDLE_BYTE_DEF  - default pattern shifted out when nothing is queued
package spi_slave_pkg;
  localparam int         DATA_W_DEF    = 8;
  localparam logic [7:0] IDLE_BYTE_DEF = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous input.
//   clk, rst_n : block clock, async active-low reset
//   d          : asynchronous input
//   q          : synchronized output (both flops reset to RST_VAL)
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/spi_slave_resp.sv
// spi_slave_resp: SPI mode-0 (CPOL=0, CPHA=0, MSB first) slave that returns
// one queued response byte per frame and delivers each received frame.
//   fpga_clk_50, fpga_reset_n : block clock, async active-low reset
//   spi_sclk/ss_n/mosi        : asynchronous SPI pins from the master
//   spi_miso, spi_miso_oe     : slave data out and its enable
//   tx_data/valid/ready       : one-entry TX holding register write port
//   rx_data, rx_valid         : received frame and its strobe
//   rx_overrun                : frame arrived too soon after the previous one
//   tx_underrun               : IDLE_BYTE was loaded for lack of TX data
//   frame_abort               : deselect in the middle of a frame
import spi_slave_pkg::*;

module spi_slave_resp #(
  parameter int                DATA_W    = DATA_W_DEF,
  parameter logic [DATA_W-1:0] IDLE_BYTE = DATA_W'(IDLE_BYTE_DEF)
) (
  input  logic              fpga_clk_50,
  input  logic              fpga_reset_n,
  input  logic              spi_sclk,
  input  logic              spi_ss_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_overrun,
  output logic              tx_underrun,
  output logic              frame_abort
);
  localparam int CNT_W   = $clog2(DATA_W) + 1;
  localparam int OVR_LIM = 2 * DATA_W + 4;
  localparam int GAP_W   = $clog2(OVR_LIM + 1);

  logic sclk_s, ss_s, mosi_s;
  logic sclk_d, ss_d, mosi_d;
  logic rise_p, fall_p, ss_fall;

  state_t state, state_nxt;

  logic [DATA_W-1:0] tx_shift, hold, load_byte;
  logic [DATA_W-2:0] rx_shift;   // the final bit joins straight into rx_data
  logic              hold_full, load_now, last_bit;
  logic [CNT_W-1:0]  cnt;
  logic [GAP_W-1:0]  gap;

  sync_2ff #(.RST_VAL(1'b0)) u_sync_sclk (.clk(fpga_clk_50), .rst_n(fpga_reset_n), .d(spi_sclk), .q(sclk_s));
  sync_2ff #(.RST_VAL(1'b1)) u_sync_ss   (.clk(fpga_clk_50), .rst_n(fpga_reset_n), .d(spi_ss_n), .q(ss_s));
  sync_2ff #(.RST_VAL(1'b0)) u_sync_mosi (.clk(fpga_clk_50), .rst_n(fpga_reset_n), .d(spi_mosi), .q(mosi_s));

  // Edge-detect stage. SCLK edges are registered pulses, and MOSI is delayed
  // by the same stage so the sampled bit lines up with rise_p.
  always_ff @(posedge fpga_clk_50 or negedge fpga_reset_n) begin
    if (!fpga_reset_n) begin
      sclk_d <= 1'b0;
      ss_d   <= 1'b1;
      mosi_d <= 1'b0;
      rise_p <= 1'b0;
      fall_p <= 1'b0;
    end else begin
      sclk_d <= sclk_s;
      ss_d   <= ss_s;
      mosi_d <= mosi_s;
      rise_p <= sclk_s & ~sclk_d;
      fall_p <= ~sclk_s & sclk_d;
    end
  end

  assign ss_fall   = ss_d & ~ss_s;
  assign last_bit  = rise_p && (cnt == CNT_W'(DATA_W - 1));
  assign load_now  = (state == LOAD) && !ss_s;
  assign load_byte = hold_full ? hold : IDLE_BYTE;

  always_ff @(posedge fpga_clk_50 or negedge fpga_reset_n) begin
    if (!fpga_reset_n) state <= IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ss_fall) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
    if (ss_s) state_nxt = IDLE;
  end

  // MISO idles high; in LOAD it already shows the byte about to be loaded so
  // the first bit is valid well before the first rising SCLK.
  always_comb begin
    spi_miso = 1'b1;
    case (state)
      LOAD:    spi_miso = load_byte[DATA_W-1];
      SHIFT:   spi_miso = tx_shift[DATA_W-1];
      default: spi_miso = 1'b1;
    endcase
  end

  assign spi_miso_oe = ~ss_s;
  assign tx_ready    = ~hold_full;

  // Holding register: a write in the LOAD cycle lands after LOAD has taken
  // the old contents, so the write wins over LOAD emptying it.
  always_ff @(posedge fpga_clk_50 or negedge fpga_reset_n) begin
    if (!fpga_reset_n) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      if (load_now) hold_full <= 1'b0;
      if (tx_valid && !hold_full) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge fpga_clk_50 or negedge fpga_reset_n) begin
    if (!fpga_reset_n) begin
      tx_shift    <= '0;
      rx_shift    <= '0;
      rx_data     <= '0;
      cnt         <= '0;
      gap         <= GAP_W'(OVR_LIM);
      rx_valid    <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
      if (gap != GAP_W'(OVR_LIM)) gap <= gap + 1'b1;

      if (ss_s) begin
        // cnt is zero between frames, so only a partial frame reports abort
        if (state == SHIFT && cnt != '0) frame_abort <= 1'b1;
        cnt <= '0;
      end else begin
        case (state)
          LOAD: begin
            tx_shift    <= load_byte;
            tx_underrun <= ~hold_full;
            cnt         <= '0;
          end
          SHIFT: begin
            if (rise_p) begin
              rx_shift <= {rx_shift[DATA_W-3:0], mosi_d};
              cnt      <= cnt + 1'b1;
              if (last_bit) begin
                rx_data    <= {rx_shift, mosi_d};
                rx_valid   <= 1'b1;
                rx_overrun <= (gap < GAP_W'(OVR_LIM));
                gap        <= '0;
              end
            end
            // The falling edge after the last bit lands in the next frame
            // with cnt==0 and must not disturb the freshly loaded byte.
            if (fall_p && cnt != '0) tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: doc/spi_slave_resp.md
SPI_SLAVE_RESP -- requirements
Module: spi_slave_resp

Interface
REQ-001 SHALL have parameter DATA_W, default 8: frame width in bits.
REQ-002 SHALL have parameter IDLE_BYTE, default 8'hFF: pattern shifted out when no TX data is queued.
REQ-003 SHALL have port fpga_clk_50, input, 1 bit: the single block clock.
REQ-004 SHALL have port fpga_reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port spi_sclk, input, 1 bit: SPI clock from the HPS spim0 master, asynchronous to the block clock.
REQ-006 SHALL have port spi_ss_n, input, 1 bit: slave select, active-low, asynchronous.
REQ-007 SHALL have port spi_mosi, input, 1 bit: master-to-slave data.
REQ-008 SHALL have port spi_miso, output, 1 bit: slave-to-master data.
REQ-009 SHALL have port spi_miso_oe, output, 1 bit: MISO output enable, high while selected.
REQ-010 SHALL have port tx_data, input, DATA_W bits: next response byte.
REQ-011 SHALL have port tx_valid, input, 1 bit: tx_data is valid.
REQ-012 SHALL have port tx_ready, output, 1 bit: TX holding register is empty.
REQ-013 SHALL have port rx_data, output, DATA_W bits: last received frame.
REQ-014 SHALL have port rx_valid, output, 1 bit: one-cycle strobe marking new rx_data.
REQ-015 SHALL have port rx_overrun, output, 1 bit: one-cycle strobe marking an RX frame lost to the previous frame.
REQ-016 SHALL have port tx_underrun, output, 1 bit: one-cycle strobe marking that IDLE_BYTE was sent.
REQ-017 SHALL have port frame_abort, output, 1 bit: one-cycle strobe marking deselect in mid-frame.

Function
REQ-018 SHALL operate in SPI mode 0 (CPOL=0, CPHA=0), MSB first: MOSI sampled on rising SCLK, MISO updated on falling SCLK.
REQ-019 SHALL pass spi_sclk, spi_ss_n and spi_mosi each through a 2-flop synchronizer, then an edge-detect register; supported SCLK is at most fpga_clk_50/8.
REQ-020 SHALL implement FSM states IDLE, LOAD, SHIFT.
- IDLE -> LOAD on synchronized ss_n falling edge.
- LOAD -> SHIFT after 1 cycle.
- SHIFT -> LOAD after the DATA_W-th rising edge (back-to-back frames).
- Any state -> IDLE on synchronized ss_n high.
REQ-021 In LOAD, SHALL copy the holding register to the TX shifter, set tx_ready=1 and clear the bit counter; if the holding register is empty, SHALL load IDLE_BYTE and pulse tx_underrun.
REQ-022 spi_miso SHALL equal the TX shifter MSB; it shall be valid from the LOAD cycle, before the first rising SCLK.
REQ-023 On each synchronized rising SCLK in SHIFT, SHALL shift synchronized MOSI into the RX shifter LSB and increment a counter of width clog2(DATA_W)+1.
REQ-024 On each falling SCLK in SHIFT, except after the final bit, SHALL left-shift the TX shifter.
REQ-025 At the DATA_W-th rising edge, SHALL load rx_data from the full RX shifter and pulse rx_valid exactly 3 fpga_clk_50 cycles after the synchronizer first captures SCLK high.
REQ-026 SHALL pulse rx_overrun alongside rx_valid when the previous rx_valid was not followed by... [no consumer handshake]: rx_overrun SHALL NOT exist as backpressure; instead it SHALL pulse when a frame completes fewer than 2*DATA_W+4 cycles after the previous one (consumer-timing warning only), and rx_data SHALL still update.
REQ-027 The holding register SHALL accept a write when tx_valid && tx_ready; tx_ready SHALL drop the next cycle.
REQ-028 When a write and a LOAD occur in the same cycle, LOAD SHALL take the old contents (or IDLE_BYTE if empty) and the write SHALL fill the register afterwards; tx_ready SHALL then be 0.
REQ-029 Deselect with 0 < counter < DATA_W SHALL discard the partial RX frame, pulse frame_abort and produce no rx_valid; the holding register SHALL be kept.
REQ-030 spi_miso_oe SHALL equal NOT synchronized ss_n.

Reset
REQ-031 While fpga_reset_n=0: state IDLE; spi_miso=1; spi_miso_oe=0; tx_ready=1; rx_data=0; all strobes 0; shifters and counter 0; synchronizer flops preset to ss_n=1, sclk=0, mosi=0.
REQ-032 Reset asserted in mid-frame SHALL abort silently (no frame_abort), and the block SHALL wait in IDLE for a fresh ss_n falling edge.

Structure
REQ-033 Package spi_slave_pkg SHALL hold the FSM state enum, DATA_W_DEF=8 and IDLE_BYTE_DEF.
REQ-034 Sub-module sync_2ff (parameterized reset value) SHALL be instantiated per asynchronous input.

Verification
REQ-035 The bench SHALL cover these scenarios with SCLK = clk/8:
- Queue 0xA5, master sends 0x3C: MISO bits 1,0,1,0,0,1,0,1; rx_data=0x3C; one rx_valid.
- No TX queued, master sends 0x00: MISO 0xFF, tx_underrun pulses once.
- Two back-to-back frames 0x12, 0x34 with 0x56 queued only before the first: replies 0x56 then 0xFF; two rx_valid strobes.
- Deselect after 5 bits: frame_abort pulses, no rx_valid; the next full frame 0x81 is received correctly.
- tx_valid during the LOAD cycle: the current frame sends the old byte, the new byte is sent in the next frame, tx_ready=0 in between.
- Reset asserted at bit 4: all outputs at reset values, no strobes; recovery on the next frame.
